// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump controller.
//
// Contents:
//   dump_state_e    - FSM state encoding (IDLE, HALT_WAIT, READ, SEND, DONE)
//   DEFAULT_DATA_W  - default register width
//   BYTES_PER_WORD  - bytes per register at the default width
//   bytes_per_word  - bytes per register for an arbitrary width
//   idx_width       - counter width for 0..n-1, never narrower than 1 bit
package reg_dump_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StHaltWait = 3'd1,
        StRead     = 3'd2,
        StSend     = 3'd3,
        StDone     = 3'd4
    } dump_state_e;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned BYTES_PER_WORD = DEFAULT_DATA_W / 8;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Serialises one DATA_W word into bytes, most-significant byte first, over a
// valid/ready handshake.
//
// Ports:
//   clk         - clock, all state on posedge
//   reset       - synchronous active-high reset
//   load        - capture load_data, clear the byte count, start presenting bytes
//   load_data   - word to serialise
//   tx_ready    - downstream accepts tx_data this cycle
//   tx_data     - current byte (top byte of the shift register)
//   tx_valid    - tx_data is valid
//   last_accept - the final byte of the word is accepted this cycle
module word_byte_serializer
    import reg_dump_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              last_accept
);

    localparam int unsigned    Bytes   = bytes_per_word(DATA_W);
    localparam int unsigned    CntW    = idx_width(Bytes);
    localparam logic [CntW-1:0] LastCnt = CntW'(Bytes - 1);

    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   cnt_q;
    logic              valid_q;
    logic              accept;

    assign accept      = valid_q & tx_ready;
    assign last_accept = accept && (cnt_q == LastCnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= load_data;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (accept) begin
            // Zeros shift in, so the register is empty once the word is out.
            shift_q <= shift_q << 8;
            cnt_q   <= last_accept ? '0 : cnt_q + CntW'(1);
            valid_q <= ~last_accept;
        end
    end

    // Byte only moves on accept, so it holds steady while the receiver stalls.
    assign tx_data  = shift_q[DATA_W-1 -: 8];
    assign tx_valid = valid_q;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: halts the pipeline, then reads every register
// through read port 1 and streams each word MSB-first as bytes to a UART
// transmitter.
//
// Ports:
//   Clock, Reset        - clock and synchronous active-high reset
//   DumpStart           - one-cycle dump request (ignored while Busy)
//   PipeHalted          - pipeline is frozen (sampled only in HALT_WAIT)
//   PipeReadRegister1   - pipeline's own read-port-1 address
//   RfReadRegister1     - address driven to register-file read port 1
//   RfReadData1         - combinational read data from port 1
//   StallReq            - asks the pipeline to halt
//   TxData/TxValid      - byte stream to the transmitter
//   TxReady             - transmitter accepts the byte this cycle
//   Busy                - controller is not idle
//   Done                - one-cycle pulse after the last byte is accepted
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              DumpStart,
    input  logic              PipeHalted,
    input  logic [ADDR_W-1:0] PipeReadRegister1,
    output logic [ADDR_W-1:0] RfReadRegister1,
    input  logic [DATA_W-1:0] RfReadData1,
    output logic              StallReq,
    output logic [7:0]        TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned     IdxW    = idx_width(NUM_REGS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

    dump_state_e     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            busy_q;
    logic            done_q;
    logic            ser_load;
    logic            ser_last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (DumpStart) begin
                    state_d = StHaltWait;
                end
            end
            StHaltWait: begin
                if (PipeHalted) begin
                    state_d = StRead;
                    idx_d   = '0;
                end
            end
            StRead: begin
                state_d = StSend;
            end
            StSend: begin
                if (ser_last) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

    // The pipeline keeps the read port until it has actually halted.
    always_comb begin
        if (state_q == StIdle || state_q == StHaltWait) begin
            RfReadRegister1 = PipeReadRegister1;
        end else begin
            RfReadRegister1 = ADDR_W'(idx_q);
        end
    end

    assign ser_load = (state_q == StRead);

    word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk         (Clock),
        .reset       (Reset),
        .load        (ser_load),
        .load_data   (RfReadData1),
        .tx_ready    (TxReady),
        .tx_data     (TxData),
        .tx_valid    (TxValid),
        .last_accept (ser_last)
    );

    // Stall request and busy cover exactly the same states.
    assign StallReq = busy_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 32, number of registers dumped (addresses 0..NUM_REGS-1).
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter DATA_W, default 32, register width; SHALL be a multiple of 8.
REQ-004 Clock  in  1  single clock; all state updates on posedge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 DumpStart  in  1  one-cycle request to dump the register file.
REQ-007 PipeHalted  in  1  pipeline reports it is frozen and issues no register writes.
REQ-008 PipeReadRegister1  in  ADDR_W  pipeline's read-port-1 address.
REQ-009 RfReadRegister1  out  ADDR_W  address driven to the register-file read port 1.
REQ-010 RfReadData1  in  DATA_W  combinational read data from register-file port 1.
REQ-011 StallReq  out  1  request to the pipeline to halt.
REQ-012 TxData  out  8  byte to the UART transmitter.
REQ-013 TxValid  out  1  TxData valid.
REQ-014 TxReady  in  1  transmitter accepts the byte this cycle.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Done  out  1  one-cycle pulse when the last byte is accepted.

Function
REQ-017 FSM states SHALL be IDLE, HALT_WAIT, READ, SEND and DONE.
REQ-018 IDLE: DumpStart=1 SHALL move to HALT_WAIT next cycle; otherwise the FSM SHALL stay in IDLE.
REQ-019 StallReq SHALL be 1 in HALT_WAIT, READ, SEND and DONE, and 0 in IDLE.
REQ-020 HALT_WAIT: the FSM SHALL clear the index to 0 and move to READ on the first cycle PipeHalted=1; it SHALL wait indefinitely otherwise.
REQ-021 RfReadRegister1 SHALL equal PipeReadRegister1 in IDLE and HALT_WAIT, and the current index in READ, SEND and DONE.
REQ-022 READ (1 cycle): the block SHALL capture RfReadData1 into a DATA_W shift register, clear the byte count, and go to SEND.
REQ-023 SEND: TxValid SHALL be 1 and TxData SHALL be the most-significant untransmitted byte, so each word goes MSB first.
REQ-024 TxData SHALL stay stable while TxValid=1 and TxReady=0; the byte SHALL advance only on TxValid&&TxReady.
REQ-025 On acceptance of byte DATA_W/8-1: if index=NUM_REGS-1, the FSM SHALL go to DONE; otherwise it SHALL increment the index and go to READ.
REQ-026 DONE (1 cycle): Done SHALL be 1, then the FSM SHALL return to IDLE.
REQ-027 TxValid SHALL be 0 outside SEND.
REQ-028 With TxReady held at 1, each register SHALL take 1+DATA_W/8 cycles; the default dump SHALL take 160 cycles from first READ to the last acceptance.
REQ-029 DumpStart while Busy=1 SHALL be ignored and not queued.
REQ-030 PipeHalted SHALL be sampled only in HALT_WAIT; once in READ/SEND it is a don't-care.
REQ-031 The index counter SHALL be sized clog2(NUM_REGS) and SHALL never wrap past NUM_REGS-1.
REQ-032 Register 0 SHALL be dumped like any other register, with no special value.

Reset
REQ-033 Reset=1 at any posedge SHALL force IDLE, index=0, byte count=0 and shift register=0.
REQ-034 During and right after reset, outputs SHALL be TxValid=0, TxData=0, StallReq=0, Busy=0 and Done=0.
REQ-035 Reset mid-dump SHALL abandon the dump without Done, even if a byte is pending.
REQ-036 Reset SHALL take priority over DumpStart in the same cycle.

Structure
REQ-037 Package reg_dump_pkg SHALL hold the FSM state encoding and BYTES_PER_WORD=DATA_W/8.
REQ-038 One sub-module, word_byte_serializer, SHALL hold the DATA_W shift register, the byte counter and the valid/ready handshake.
REQ-039 The serializer SHALL report last-byte acceptance to the FSM.
REQ-040 The read-address mux SHALL live in reg_dump_ctrl.

Verification
REQ-041 Regfile preloaded with reg[i]=0x01020300+i, TxReady=1, PipeHalted=1, DumpStart pulse -> 128 bytes in order 01,02,03,00,01,02,03,01,...; Done exactly 160 cycles after the first READ.
REQ-042 PipeHalted held 0 for 10 cycles after DumpStart -> StallReq=1, TxValid=0, Busy=1 throughout; READ starts the cycle after PipeHalted rises.
REQ-043 TxReady toggled randomly, including 5-cycle low runs -> every TxData byte stable while stalled, no byte lost or duplicated, stream identical to REQ-041.
REQ-044 Reset asserted while sending byte 2 of register 7 -> next cycle all outputs 0 and Busy=0, no Done; a new DumpStart restarts at register 0 byte 0.
REQ-045 Second DumpStart while Busy, plus DumpStart in the same cycle as Done -> exactly one 128-byte dump, RfReadRegister1 = PipeReadRegister1 once back in IDLE.
